mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   Load/store unit between the RV32I core and the word-wide zero-delay data RAM. Converts core
//   LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word RAM accesses.
//   - Loads: extracts and sign/zero-extends the addressed lane.
//   - Sub-word stores: read-modify-write merge.
//   - Misaligned or illegal requests: rejected with a fault response; no RAM write is issued.
// PARAMETERS
//   dataW   32  data word width (fixed 4 byte lanes; only 32 supported)
//   addrW   32  byte address width
// PORTS
//   clock            in   1      clock, rising edge
//   reset            in   1      asynchronous, active-high
//   req_valid        in   1      core request present
//   req_ready        out  1      unit can accept (high only in IDLE)
//   req_write        in   1      1 = store, 0 = load
//   req_funct3       in   3      RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr         in   addrW  byte address
//   req_wdata        in   dataW  store data (lane 0 aligned, i.e. rs2)
//   resp_valid       out  1      one-cycle response strobe
//   resp_rdata       out  dataW  extended load data (0 for stores and faults)
//   resp_misaligned  out  1      fault: H at addr[0]=1, W at addr[1:0]!=0
//   resp_illegal     out  1      fault: load funct3 011/110/111, store funct3 >= 011
//   ram_addr         out  addrW  word-aligned byte address {addr[addrW-1:2],2'b00}
//   ram_wdata        out  dataW  word written to RAM
//   ram_we           out  1      RAM write enable, sampled by RAM on rising edge
//   ram_rdata        in   dataW  RAM combinational read data for ram_addr
// BEHAVIOUR
//   Reset is async and forces: state IDLE; resp_valid/misaligned/illegal 0; resp_rdata 0;
//     ram_addr 0; ram_wdata 0; ram_we 0. ram_we is decoded from registered state, so a reset
//     mid-operation drops it immediately and no partial write completes.
//   FSM states: IDLE, READ, WRITE, RESP.
//   IDLE: req_ready=1. On req_valid, capture write/funct3/addr/wdata and set ram_addr, then:
//     - illegal or misaligned -> RESP with the matching fault bit (illegal has priority)
//     - load                  -> READ
//     - SW                    -> WRITE, with ram_wdata=req_wdata
//     - SB/SH                 -> READ
//   READ:
//     - load: latch the extracted value into resp_rdata, go to RESP.
//     - store: ram_wdata = ram_rdata with the lane(s) replaced, go to WRITE.
//       SB: byte addr[1:0] <- wdata[7:0].
//       SH: half addr[1] <- wdata[15:0].
//   WRITE: ram_we=1 for exactly this cycle; ram_addr and ram_wdata stable; next state RESP.
//   RESP: resp_valid=1 for exactly one cycle; fault bits and rdata valid alongside it. Next
//     state IDLE. resp_rdata, resp_misaligned and resp_illegal clear on leaving RESP.
//   Load extraction: byte lane = ram_rdata[8*addr[1:0] +: 8]; half lane = ram_rdata[16*addr[1] +: 16].
//     B/H sign-extend; BU/HU zero-extend; W passes the word through.
//   Latency from the accept edge T:
//     - load / SW response at T+2
//     - SB/SH response at T+3
//     - fault response at T+1
//   req_ready=0 in READ, WRITE and RESP; a request is never accepted in the same cycle as resp_valid.
//   ram_addr holds its last captured value while in IDLE; ram_we=0 outside WRITE.
//   Stores to RAM word 0/1 (input ports) are issued normally; the RAM discards them.
//     Sub-word stores to output words 2/3 merge correctly, because the RAM reads them back.
//   Address wrap: upper address bits pass through unchanged; no bounds checking is done here.
// TESTING
//   1 RAM[0x100]=0x80112233; LB @0x103 -> resp_rdata 0xFFFFFF80 at T+2.
//     LBU @0x103 -> 0x00000080. LH @0x102 -> 0xFFFF8011. LHU -> 0x00008011.
//   2 RAM[0x100]=0x11223344; SH @0x102 wdata 0xAAAABEEF -> ram_we only at T+2,
//     ram_wdata 0xBEEF3344, resp_valid T+3. SB @0x101 wdata 0x55 -> 0x11225544.
//   3 SW @0x101 -> resp_valid T+1 with resp_misaligned=1; ram_we never high.
//     LW funct3=011 -> resp_illegal=1, resp_misaligned=0.
//   4 Hold req_valid high for 3 back-to-back LW: req_ready low while busy.
//     Accepts land at T, T+3, T+6; each response is a single cycle.
//   5 Assert reset during READ of an SB: outputs zero asynchronously, ram_we stays 0, RAM unchanged.
//     First request after reset deassert completes normally.
//   6 SW @0x8 wdata 0xCAFEF00D -> OutWord1=0xCAFEF00D. SB @0x9 wdata 0x77 -> OutWord1=0xCAFE770D.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the RV32I core and a word-wide, zero-delay data RAM.
// Sub-word loads are lane-extracted; sub-word stores use a read-modify-write merge.
module mem_access_unit #(
    parameter int dataW = 32,
    parameter int addrW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [addrW-1:0] req_addr,
    input  logic [dataW-1:0] req_wdata,
    output logic             resp_valid,
    output logic [dataW-1:0] resp_rdata,
    output logic             resp_misaligned,
    output logic             resp_illegal,
    output logic [addrW-1:0] ram_addr,
    output logic [dataW-1:0] ram_wdata,
    output logic             ram_we,
    input  logic [dataW-1:0] ram_rdata
);

    localparam int LANES = dataW / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_write;
    logic             w_write_next;
    logic [2:0]       r_funct3;
    logic [2:0]       w_funct3_next;
    logic [1:0]       r_addr_lo;
    logic [1:0]       w_addr_lo_next;
    logic [15:0]      r_wdata;
    logic [15:0]      w_wdata_next;
    logic [addrW-1:0] r_ram_addr;
    logic [addrW-1:0] w_ram_addr_next;
    logic [dataW-1:0] r_ram_wdata;
    logic [dataW-1:0] w_ram_wdata_next;
    logic [dataW-1:0] r_resp_rdata;
    logic [dataW-1:0] w_resp_rdata_next;
    logic             r_misaligned;
    logic             w_misaligned_next;
    logic             r_illegal;
    logic             w_illegal_next;

    // Request classification, evaluated on the raw request in IDLE.
    logic w_req_illegal;
    logic w_req_misaligned;

    always_comb begin
        if (req_write) begin
            w_req_illegal = (req_funct3 >= 3'b011);
        end else begin
            w_req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        w_req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                         || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    end

    // Per-lane views of the RAM word and the merged store word.
    logic [7:0]       w_rd_lane [LANES];
    logic [7:0]       w_st_lane [LANES];
    logic [LANES-1:0] w_lane_sel;
    logic [dataW-1:0] w_merged;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_rd_lane[gi]  = ram_rdata[8*gi +: 8];
            assign w_lane_sel[gi] = (r_funct3[1:0] == 2'b00) ? (r_addr_lo == 2'(gi))
                                                             : (r_addr_lo[1] == 1'(gi / 2));
            assign w_st_lane[gi]  = (r_funct3[1:0] == 2'b00) ? r_wdata[7:0]
                                                             : r_wdata[8*(gi % 2) +: 8];
            assign w_merged[8*gi +: 8] = w_lane_sel[gi] ? w_st_lane[gi] : w_rd_lane[gi];
        end
    endgenerate

    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [dataW-1:0] w_ld_value;

    assign w_ld_byte = w_rd_lane[r_addr_lo];
    assign w_ld_half = r_addr_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        w_ld_value = ram_rdata;
        case (r_funct3)
            F3_B:    w_ld_value = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_BU:   w_ld_value = {24'h0, w_ld_byte};
            F3_H:    w_ld_value = {{16{w_ld_half[15]}}, w_ld_half};
            F3_HU:   w_ld_value = {16'h0, w_ld_half};
            default: w_ld_value = ram_rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_wdata      <= 16'h0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_resp_rdata <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_write      <= w_write_next;
            r_funct3     <= w_funct3_next;
            r_addr_lo    <= w_addr_lo_next;
            r_wdata      <= w_wdata_next;
            r_ram_addr   <= w_ram_addr_next;
            r_ram_wdata  <= w_ram_wdata_next;
            r_resp_rdata <= w_resp_rdata_next;
            r_misaligned <= w_misaligned_next;
            r_illegal    <= w_illegal_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_write_next      = r_write;
        w_funct3_next     = r_funct3;
        w_addr_lo_next    = r_addr_lo;
        w_wdata_next      = r_wdata;
        w_ram_addr_next   = r_ram_addr;
        w_ram_wdata_next  = r_ram_wdata;
        w_resp_rdata_next = r_resp_rdata;
        w_misaligned_next = r_misaligned;
        w_illegal_next    = r_illegal;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_write_next    = req_write;
                    w_funct3_next   = req_funct3;
                    w_addr_lo_next  = req_addr[1:0];
                    w_wdata_next    = req_wdata[15:0];
                    w_ram_addr_next = {req_addr[addrW-1:2], 2'b00};
                    if (w_req_illegal) begin
                        w_illegal_next = 1'b1;
                        w_state_next   = RESP;
                    end else if (w_req_misaligned) begin
                        w_misaligned_next = 1'b1;
                        w_state_next      = RESP;
                    end else if (!req_write) begin
                        w_state_next = READ;
                    end else if (req_funct3 == F3_W) begin
                        w_ram_wdata_next = req_wdata;
                        w_state_next     = WRITE;
                    end else begin
                        w_state_next = READ;
                    end
                end
            end
            READ: begin
                if (r_write) begin
                    w_ram_wdata_next = w_merged;
                    w_state_next     = WRITE;
                end else begin
                    w_resp_rdata_next = w_ld_value;
                    w_state_next      = RESP;
                end
            end
            WRITE: begin
                w_state_next = RESP;
            end
            RESP: begin
                w_resp_rdata_next = '0;
                w_misaligned_next = 1'b0;
                w_illegal_next    = 1'b0;
                w_state_next      = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Strobes decode from the state register so reset removes them at once.
    assign req_ready       = (r_state == IDLE);
    assign resp_valid      = (r_state == RESP);
    assign ram_we          = (r_state == WRITE);
    assign resp_rdata      = r_resp_rdata;
    assign resp_misaligned = r_misaligned;
    assign resp_illegal    = r_illegal;
    assign ram_addr        = r_ram_addr;
    assign ram_wdata       = r_ram_wdata;

endmodule
